// File: rtl/rv32_mem_stage.sv
// RV32 memory stage: issues loads/stores on a valid/ready data bus, stalls upstream while a
// transaction is outstanding, and registers the writeback buffer.
package rv32_mem_pkg;
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [3:0] {MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_e;

   typedef struct packed {
      mem_op_e    mem_op;
      logic       reg_write;
      logic [4:0] rd;
   } decoded_instr_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    mem_addr;
      logic [31:0]    wb_result;
   } exec_mem_buffer_t;

   typedef struct packed {
      logic [31:0]    instr;
      logic [31:0]    pc;
      decoded_instr_t decoded_instr;
      logic [31:0]    wb_result;
   } mem_wb_buffer_t;

   function automatic decoded_instr_t create_nop_ctrl();
      decoded_instr_t c;
      c.mem_op    = MEM_NONE;
      c.reg_write = 1'b0;
      c.rd        = 5'd0;
      return c;
   endfunction
endpackage

module rv32_mem_stage
   import rv32_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  exec_mem_buffer_t exec_mem_buff,
   input  logic             stop,
   output logic             mem_stall,
   output mem_wb_buffer_t   mem_wb_buff,
   output logic             dmem_req_valid,
   input  logic             dmem_req_ready,
   output logic             dmem_req_we,
   output logic [31:0]      dmem_req_addr,
   output logic [31:0]      dmem_req_wdata,
   output logic [3:0]       dmem_req_wstrb,
   input  logic             dmem_rsp_valid,
   input  logic [31:0]      dmem_rsp_data,
   output logic             misaligned_fault,
   output logic             bus_fault
);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

   state_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]    hold_q, hold_d;
   mem_wb_buffer_t mem_wb_q, mem_wb_d;

   mem_op_e     op;
   logic [1:0]  b;
   logic        is_load, is_store, misaligned;
   logic [7:0]  rsp_byte;
   logic [15:0] rsp_half;
   logic [31:0] load_val;
   logic [31:0] val;

   assign op       = exec_mem_buff.decoded_instr.mem_op;
   assign b        = exec_mem_buff.mem_addr[1:0];
   assign val      = exec_mem_buff.wb_result;
   assign is_load  = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
   assign is_store = (op == SB) || (op == SH) || (op == SW);
   assign misaligned = (((op == LH) || (op == LHU) || (op == SH)) && b[0]) ||
                       (((op == LW) || (op == SW)) && (b != 2'b00));

   function automatic mem_wb_buffer_t nop_buffer();
      mem_wb_buffer_t n;
      n.instr         = RV_NOP;
      n.pc            = 32'd0;
      n.decoded_instr = create_nop_ctrl();
      n.wb_result     = 32'd0;
      return n;
   endfunction

   function automatic mem_wb_buffer_t passthrough(input exec_mem_buffer_t e, input logic [31:0] r);
      mem_wb_buffer_t p;
      p.instr         = e.instr;
      p.pc            = e.pc;
      p.decoded_instr = e.decoded_instr;
      p.wb_result     = r;
      return p;
   endfunction

   // Bus request fields come straight from the upstream buffer, which is held while stalled.
   assign dmem_req_we   = is_store;
   assign dmem_req_addr = {exec_mem_buff.mem_addr[31:2], 2'b00};

   always_comb begin
      dmem_req_wdata = val;
      dmem_req_wstrb = 4'b0000;
      case (op)
         SB: begin
            dmem_req_wdata = {4{val[7:0]}};
            dmem_req_wstrb = 4'b0001 << b;
         end
         SH: begin
            dmem_req_wdata = {2{val[15:0]}};
            dmem_req_wstrb = 4'b0011 << b;
         end
         SW:      dmem_req_wstrb = 4'b1111;
         default: ;
      endcase
   end

   always_comb begin
      rsp_byte = dmem_rsp_data[7:0];
      case (b)
         2'd1:    rsp_byte = dmem_rsp_data[15:8];
         2'd2:    rsp_byte = dmem_rsp_data[23:16];
         2'd3:    rsp_byte = dmem_rsp_data[31:24];
         default: ;
      endcase
      rsp_half = b[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
      case (op)
         LB:      load_val = {{24{rsp_byte[7]}}, rsp_byte};
         LBU:     load_val = {24'd0, rsp_byte};
         LH:      load_val = {{16{rsp_half[15]}}, rsp_half};
         LHU:     load_val = {16'd0, rsp_half};
         default: load_val = dmem_rsp_data;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      hold_d           = hold_q;
      mem_wb_d         = mem_wb_q;
      mem_stall        = 1'b0;
      dmem_req_valid   = 1'b0;
      misaligned_fault = 1'b0;
      bus_fault        = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!(is_load || is_store)) begin
               if (!stop) mem_wb_d = passthrough(exec_mem_buff, val);
            end else if (misaligned) begin
               if (!stop) begin
                  mem_wb_d         = passthrough(exec_mem_buff, 32'd0);
                  misaligned_fault = 1'b1;
               end
            end else begin
               mem_stall = 1'b1;
               if (!stop) mem_wb_d = nop_buffer();
               state_d = REQ;
            end
         end
         REQ: begin
            mem_stall      = 1'b1;
            dmem_req_valid = 1'b1;
            if (!stop) mem_wb_d = nop_buffer();
            if (dmem_req_ready) begin
               cnt_d   = '0;
               state_d = is_store ? DONE : RESP;
            end
         end
         RESP: begin
            mem_stall = 1'b1;
            if (!stop) mem_wb_d = nop_buffer();
            cnt_d = cnt_q + CNT_ONE;
            if (dmem_rsp_valid) begin
               hold_d  = load_val;
               state_d = DONE;
            end else if (cnt_q == CNT_MAX) begin
               hold_d    = 32'd0;
               bus_fault = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            // The request is never re-issued here; stop only delays the writeback.
            if (!stop) begin
               mem_wb_d = passthrough(exec_mem_buff, is_store ? val : hold_q);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hold_q   <= 32'd0;
         mem_wb_q <= nop_buffer();
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign mem_wb_buff = mem_wb_q;
endmodule
